flag_gen_seq: RTL

- Multi-cycle comparator that produces the Zero/Negative/OverFlow/Carry flag set consumed by the branch-decision logic.
- Computes rs1 - rs2, implemented as rs1 + ~rs2 + 1, CHUNK bits per cycle, to keep the adder small in the area-reduced core.
- Uses valid/ready handshakes on both sides.
- Carries a tag (e.g. funct3 plus ROB/PC index) through unchanged, so the downstream branch decision pairs flags with the right instruction.

---
 rtl/flag_gen_seq_if.sv | 20 ++
 rtl/flag_gen_seq.sv | 67 ++++++
 2 files changed

// File: rtl/flag_gen_seq_if.sv
// flag_gen_seq_if: operand/result handshake bundle for flag_gen_seq
//   master: drives in_valid, rs1, rs2, tag_in, flush, out_ready; receives in_ready and results
//   slave:  the comparator side of the same signals
interface flag_gen_seq_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 3
);
  logic             in_valid, in_ready, flush, out_valid, out_ready;
  logic [WIDTH-1:0] rs1, rs2, result;
  logic [TAG_W-1:0] tag_in, tag_out;
  logic             Zero, Negative, OverFlow, Carry;
  modport master (
    output in_valid, rs1, rs2, tag_in, flush, out_ready,
    input  in_ready, out_valid, result, Zero, Negative, OverFlow, Carry, tag_out
  );
  modport slave (
    input  in_valid, rs1, rs2, tag_in, flush, out_ready,
    output in_ready, out_valid, result, Zero, Negative, OverFlow, Carry, tag_out
  );
endinterface

// File: rtl/flag_gen_seq.sv
// flag_gen_seq: multi-cycle rs1 - rs2 producing Zero/Negative/OverFlow/Carry, CHUNK bits per cycle
//   clk, rst_n (async, active low)
//   bus.slave: in_valid/in_ready + rs1, rs2, tag_in; out_valid/out_ready + result, flags, tag_out; flush
module flag_gen_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  flag_gen_seq_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, next;
  logic [WIDTH-1:0] a, b, res;
  logic [TAG_W-1:0] tag;
  logic [CW-1:0]    cnt;
  logic             carry, zacc, last;
  logic [CHUNK:0]   sum;
  assign sum  = {1'b0, a[cnt*CHUNK +: CHUNK]} + {1'b0, b[cnt*CHUNK +: CHUNK]} + (CHUNK+1)'(carry);
  assign last = cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = bus.flush ? IDLE :
           state == IDLE ? (bus.in_valid ? RUN : IDLE) :
           state == RUN  ? (last ? DONE : RUN) :
           (bus.out_ready ? IDLE : DONE);
  end
  // b holds ~rs2 so the subtract is a plain add with carry-in 1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a     <= '0;
      b     <= '0;
      res   <= '0;
      tag   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
    end else if (!bus.flush) begin
      if (state == IDLE && bus.in_valid) begin
        a     <= bus.rs1;
        b     <= ~bus.rs2;
        tag   <= bus.tag_in;
        cnt   <= '0;
        carry <= 1'b1;
        zacc  <= 1'b1;
      end else if (state == RUN) begin
        res[cnt*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
        carry <= sum[CHUNK];
        zacc  <= zacc & ~|sum[CHUNK-1:0];
        cnt   <= cnt + 1'b1;
      end
    end
  // carry/zacc/res/operands are frozen outside RUN, so the flags hold through DONE
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.result    = res;
  assign bus.tag_out   = tag;
  assign bus.Zero      = zacc;
  assign bus.Negative  = res[WIDTH-1];
  assign bus.Carry     = carry;
  assign bus.OverFlow  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
endmodule
